// File: rtl/lcd_seq_addr_gen_if.sv
// lcd_seq_addr_gen_if: address valid/ready handshake between the sequencer and the LCD write engine
interface lcd_seq_addr_gen_if #(
  parameter int ADDR_WIDTH = 17
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic                  addr_ready;
  modport master (output addr, output addr_valid, input addr_ready);
  modport slave  (input addr, input addr_valid, output addr_ready);
endinterface

// File: rtl/lcd_seq_addr_gen.sv
// lcd_seq_addr_gen: walks CMD, PIX and TAIL address phases and hands each address out over valid/ready
module lcd_seq_addr_gen #(
  parameter int ADDR_WIDTH   = 17,
  parameter int CMD_LEN      = 106,
  parameter int PIX_COUNT    = 76800,
  parameter int PIX_MODE     = 0,
  parameter int PIX_BASE     = 106,
  parameter int TAIL_LEN     = 1,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  lcd_seq_addr_gen_if.master  bus,
  output logic [1:0]          phase_o,
  output logic                busy_o,
  output logic                init_done_o,
  output logic                frame_done_o
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] CMD_LAST   = AW'(CMD_LEN - 1);
  localparam logic [AW-1:0] PIX_LAST   = AW'(PIX_COUNT - 1);
  localparam logic [AW-1:0] TAIL_LAST  = AW'(TAIL_LEN > 0 ? TAIL_LEN - 1 : 0);
  localparam logic [AW-1:0] PIX_ADDR0  = AW'(PIX_MODE != 0 ? PIX_BASE : CMD_LEN);
  localparam logic [AW-1:0] TAIL_ADDR0 = AW'(CMD_LEN + 1);
  // low two state bits double as the phase code, so phase/busy come straight off the register
  typedef enum logic [2:0] {IDLE = 3'd0, CMD = 3'd1, PIX = 3'd2, TAIL = 3'd3, DONE = 3'd4} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d, addr_q, addr_d, cnt_inc;
  logic            valid_q, valid_d, init_q, init_d, fdone_q, fdone_d, xfer, eof;
  assign xfer    = valid_q && bus.addr_ready;
  assign cnt_inc = cnt_q + AW'(1);
  assign eof     = xfer && ((state_q == PIX && cnt_q == PIX_LAST && TAIL_LEN == 0) ||
                            (state_q == TAIL && cnt_q == TAIL_LAST));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    init_d  = init_q;
    fdone_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = CMD;
        cnt_d   = '0;
        addr_d  = '0;
        valid_d = 1'b1;
        init_d  = 1'b0;
      end
      CMD: if (xfer && cnt_q == CMD_LAST) begin
        state_d = PIX;
        cnt_d   = '0;
        addr_d  = PIX_ADDR0;
        init_d  = 1'b1;
      end else if (xfer) begin
        cnt_d  = cnt_inc;
        addr_d = cnt_inc;
      end
      PIX: if (xfer && cnt_q != PIX_LAST) begin
        cnt_d  = cnt_inc;
        addr_d = PIX_MODE != 0 ? PIX_ADDR0 + cnt_inc : PIX_ADDR0;
      end else if (xfer && TAIL_LEN > 0) begin
        state_d = TAIL;
        cnt_d   = '0;
        addr_d  = TAIL_ADDR0;
      end
      TAIL: if (xfer && cnt_q != TAIL_LAST) begin
        cnt_d  = cnt_inc;
        addr_d = TAIL_ADDR0 + cnt_inc;
      end
      default: ;
    endcase
    // refresh re-enters PIX with the first pixel already presented, so there is no bubble
    if (eof) begin
      fdone_d = 1'b1;
      state_d = AUTO_REFRESH != 0 ? PIX : DONE;
      cnt_d   = '0;
      addr_d  = AUTO_REFRESH != 0 ? PIX_ADDR0 : addr_q;
      valid_d = AUTO_REFRESH != 0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      init_q  <= init_d;
      fdone_q <= fdone_d;
    end
  end
  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign phase_o        = state_q[1:0];
  assign busy_o         = |state_q[1:0];
  assign init_done_o    = init_q;
  assign frame_done_o   = fdone_q;
endmodule

// File: doc/lcd_seq_addr_gen.md
Name: lcd_seq_addr_gen

Overview:
- Parametrised address sequencer for the LCD init/frame ROM path.
- Walks three address phases in order: command words, pixel words, then tail commands.
- Pixel phase either holds one fill address or streams a framebuffer range.
- Hands each address to the LCD write engine over a valid/ready handshake and flags init completion; optionally loops pixel+tail phases for continuous refresh.

Parameters:
- ADDR_WIDTH, 17, width of addr and all internal counters; must be wide enough for every address and for PIX_COUNT-1.
- CMD_LEN, 106, number of init command words at addresses 0..CMD_LEN-1 (>=1).
- PIX_COUNT, 76800, number of pixel beats per frame (>=1).
- PIX_MODE, 0, 0 = hold address CMD_LEN for every pixel beat; 1 = stream PIX_BASE+i, i=0..PIX_COUNT-1.
- PIX_BASE, 106, first framebuffer address in PIX_MODE=1; ignored in PIX_MODE=0.
- TAIL_LEN, 1, number of post-pixel command words at CMD_LEN+1..CMD_LEN+TAIL_LEN (>=0).
- AUTO_REFRESH, 0, 0 = stop in DONE after tail; 1 = return to PIX after tail, forever.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE or DONE.
- addr_ready  in  1  write engine accepts the current addr.
- addr  out  ADDR_WIDTH  ROM address, registered.
- addr_valid  out  1  addr is valid for transfer.
- phase  out  2  0 = idle/done, 1 = CMD, 2 = PIX, 3 = TAIL.
- busy  out  1  high in CMD, PIX and TAIL.
- init_done  out  1  sticky; set when the last CMD word transfers; cleared by rst or start.
- frame_done  out  1  one-cycle pulse when the final beat of a frame (last tail word, or last pixel if TAIL_LEN=0) transfers.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge, any state, including mid-sequence): state IDLE, addr=0, addr_valid=0, phase=0, busy=0, init_done=0, frame_done=0, beat counter=0. No partial transfer is completed.
- Transfer rule: a beat transfers on an edge where addr_valid && addr_ready. While addr_valid && !addr_ready, addr and phase hold stable.
- Outputs are registered; the next address appears the cycle after a transfer, so back-to-back beats are possible at 1/clk.
- IDLE:
  - start -> next cycle: CMD, addr=0, addr_valid=1, init_done=0.
- CMD:
  - addr = beat count 0..CMD_LEN-1.
  - On transfer of CMD_LEN-1: init_done<=1, go to PIX, counter=0.
- PIX:
  - addr = CMD_LEN (mode 0) or PIX_BASE+counter (mode 1).
  - On transfer of beat PIX_COUNT-1: go to TAIL if TAIL_LEN>0. Otherwise it is end of frame.
- TAIL:
  - addr = CMD_LEN+1+counter.
  - On transfer of the last tail beat: end of frame.
- End of frame:
  - frame_done pulses for 1 cycle.
  - AUTO_REFRESH=0: go to DONE with addr_valid=0, addr holding the last value.
  - AUTO_REFRESH=1: go to PIX with counter=0 and no bubble cycle; the next cycle presents the first pixel address.
- DONE:
  - phase=0, busy=0, init_done stays 1.
  - start -> CMD as from IDLE, init_done cleared.
- start while busy: ignored, no effect on state, counters or outputs.
- addr_ready while addr_valid=0: ignored.
- Arithmetic: all address math is ADDR_WIDTH bits unsigned; no wrap is permitted under legal parameters. Counter compare uses ==, with no magnitude chains.
- Latency: start to first valid addr is 1 cycle. Total beats per non-refresh run = CMD_LEN+PIX_COUNT+TAIL_LEN.

Test Plan:
- Default-shape smoke (CMD_LEN=4, PIX_COUNT=8, PIX_MODE=0, TAIL_LEN=2), addr_ready=1, start pulse -> addr sequence 0,1,2,3, then 4 ×8, then 5,6. init_done rises the cycle after addr 3 transfers. frame_done pulses once after addr 6. addr_valid falls 14 cycles after the first valid.
- Backpressure: same params, addr_ready toggles 1/0 each cycle -> identical address sequence with no skips or duplicates per transfer. addr stays constant whenever ready=0.
- Stream mode (PIX_MODE=1, PIX_BASE=100, PIX_COUNT=3, TAIL_LEN=0) -> pixels 100,101,102. frame_done pulses on the transfer of 102, then DONE.
- Auto refresh (AUTO_REFRESH=1, CMD_LEN=2, PIX_COUNT=2, TAIL_LEN=1) -> 0,1,2,2,3,2,2,3,... with frame_done every 3 beats. init_done stays 1 throughout. No idle cycle between frames.
- Reset mid-PIX: assert rst on pixel beat 5 -> next cycle all outputs are at reset values. A subsequent start restarts at addr 0 with init_done=0.
- start ignored when busy (pulse during CMD beat 2) -> sequence unchanged. start in DONE -> fresh sequence from addr 0, init_done cleared until CMD completes.
